// File: rtl/btn_gesture_decoder.sv
// rtl/btn_gesture_decoder.sv - turns a debounced button level into press/release/click/long-press pulses
module btn_gesture_decoder #(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter int unsigned LONG_PRESS_MS = 500,
  parameter int unsigned DOUBLE_GAP_MS = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_click,
  output logic double_click,
  output logic long_press
);

  localparam int unsigned LONG_CNT  = (CLK_FREQ / 1000) * LONG_PRESS_MS;
  localparam int unsigned GAP_CNT   = (CLK_FREQ / 1000) * DOUBLE_GAP_MS;
  localparam logic [31:0] LONG_LAST = 32'(LONG_CNT - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CNT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_LONG   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic        r_held;
  logic        r_press;
  logic        r_release;
  logic        r_short;
  logic        r_double;
  logic        r_long;
  logic        w_rise;
  logic        w_fall;
  logic        w_short;
  logic        w_double;
  logic        w_long;

  assign w_rise = btn_level & ~r_held;
  assign w_fall = ~btn_level & r_held;

  // Edges are checked before timeouts so an edge on the threshold cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short     = 1'b0;
    w_double    = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_PRESS1;
          w_cnt_nxt   = 32'd0;
        end
      end
      S_PRESS1: begin
        if (w_fall) begin
          w_state_nxt = S_WAIT2;
          w_cnt_nxt   = 32'd0;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = S_LONG;
          w_cnt_nxt   = 32'd0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
      S_WAIT2: begin
        if (w_rise) begin
          w_state_nxt = S_PRESS2;
          w_cnt_nxt   = 32'd0;
        end else if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 32'd0;
          w_short     = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
      S_PRESS2: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 32'd0;
          w_double    = 1'b1;
        end else if (r_cnt == LONG_LAST) begin
          // Holding the second press too long abandons the first click.
          w_state_nxt = S_LONG;
          w_cnt_nxt   = 32'd0;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
      S_LONG: begin
        if (w_fall) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 32'd0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 32'd0;
      r_held    <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_short   <= 1'b0;
      r_double  <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_held    <= btn_level;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_short   <= w_short;
      r_double  <= w_double;
      r_long    <= w_long;
    end
  end

  assign held          = r_held;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign short_click   = r_short;
  assign double_click  = r_double;
  assign long_press    = r_long;

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// tb/tb_btn_gesture_decoder.sv - scoreboard bench for btn_gesture_decoder
module tb_btn_gesture_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_level = 1'b0;
  logic held, press_pulse, release_pulse, short_click, double_click, long_press;

  localparam logic [4:0] EV_P = 5'b10000;
  localparam logic [4:0] EV_R = 5'b01000;
  localparam logic [4:0] EV_S = 5'b00100;
  localparam logic [4:0] EV_D = 5'b00010;
  localparam logic [4:0] EV_L = 5'b00001;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   t0;
  logic exp_held;

  btn_gesture_decoder #(
    .CLK_FREQ     (1000),
    .LONG_PRESS_MS(8),
    .DOUBLE_GAP_MS(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .held         (held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .double_click (double_click),
    .long_press   (long_press)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_held <= 1'b0;
    else        exp_held <= btn_level;
  end

  // Monitor: every cycle with any pulse must match the next queued expectation.
  always @(negedge clk) begin
    logic [4:0] w;
    exp_t e;
    w = {press_pulse, release_pulse, short_click, double_click, long_press};
    if (w !== 5'b0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, w);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.ev !== w) begin
          n_bad++;
          $display("FAIL event cyc=%0d got=%b required cyc=%0d ev=%b", cyc, w, e.cyc, e.ev);
        end
      end
    end
    if (rst_n) begin
      n_cmp++;
      if (held !== exp_held) begin
        n_bad++;
        $display("FAIL held cyc=%0d got=%b required=%b", cyc, held, exp_held);
      end
    end
  end

  task automatic push(input int c, input logic [4:0] ev);
    q.push_back('{c, ev});
  endtask

  task automatic hold(input logic lvl, input int n);
    repeat (n) begin
      btn_level = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero(input string name);
    logic [5:0] v;
    v = {held, press_pulse, release_pulse, short_click, double_click, long_press};
    n_cmp++;
    if (v !== 6'b0) begin
      n_bad++;
      $display("FAIL %s got=%b required=000000", name, v);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst_n = 1'b1;
    hold(1'b0, 3);

    // 1: single short click
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 3, EV_R); push(t0 + 8, EV_S);
    hold(1'b1, 3); hold(1'b0, 15);

    // 2: double click
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 3, EV_R); push(t0 + 5, EV_P); push(t0 + 7, EV_R | EV_D);
    hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 15);

    // 3: long press
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 8, EV_L); push(t0 + 12, EV_R);
    hold(1'b1, 12); hold(1'b0, 10);

    // 4: release exactly on the long-press threshold cycle
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 8, EV_R); push(t0 + 13, EV_S);
    hold(1'b1, 8); hold(1'b0, 15);

    // 5: reset during WAIT2 discards the pending click
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 3, EV_R);
    hold(1'b1, 3); hold(1'b0, 2);
    rst_n = 1'b0;
    #1;
    check_zero("reset_in_wait2");
    hold(1'b0, 2);
    check_zero("reset_held_low");
    rst_n = 1'b1;
    hold(1'b0, 10);
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 2, EV_R); push(t0 + 7, EV_S);
    hold(1'b1, 2); hold(1'b0, 12);

    // 6: second press held long
    t0 = cyc + 1;
    push(t0, EV_P); push(t0 + 2, EV_R); push(t0 + 4, EV_P); push(t0 + 12, EV_L); push(t0 + 14, EV_R);
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 10); hold(1'b0, 10);

    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event got=none required cyc=%0d ev=%b", e.cyc, e.ev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
